// File: rtl/apu_pkg.sv
// Shared APU constants and types.
// Duty tables, frame sequencer decode and envelope config.
package apu_pkg;

    // Duty waveforms, bit index = duty_step.
    localparam logic [7:0] DUTY [4] = '{
        8'b1000_0000,
        8'b1000_0001,
        8'b1110_0001,
        8'b0111_1110
    };

    localparam logic [6:0] LEN_MAX     = 7'd64;
    localparam logic [7:0] FS_LEN_MASK = 8'b0101_0101;
    localparam logic [2:0] FS_ENV_STEP = 3'd7;

    typedef enum logic {
        ENV_DOWN = 1'b0,
        ENV_UP   = 1'b1
    } env_dir_e;

    // Same bit layout as the NRx2 register.
    typedef struct packed {
        logic [3:0] init_vol;
        env_dir_e   dir;
        logic [2:0] period;
    } env_cfg_t;

    function automatic logic duty_bit(
        input logic [1:0] sel,
        input logic [2:0] step
    );
        logic [7:0] pat;
        pat = DUTY[sel];
        return pat[step];
    endfunction

endpackage

// File: rtl/apu_envelope.sv
// Volume envelope: volume, period timer and saturation freeze.
// Shared by the pulse and noise channels.
module apu_envelope
    import apu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trigger,
    input  logic       env_clk,
    input  env_cfg_t   cfg,
    output logic [3:0] vol_q,
    output logic [3:0] vol_d
);

    logic [2:0] timer_q;
    logic [2:0] timer_d;
    logic       frozen_q;
    logic       frozen_d;
    logic       at_limit;
    logic       expire;

    assign at_limit = (cfg.dir == ENV_UP) ? (vol_q == 4'hF)
                                          : (vol_q == 4'h0);
    // An idle timer (0) expires on the next clock, like a count of 1.
    assign expire = (timer_q <= 3'd1);

    // Trigger reloads everything; otherwise count down and step volume.
    always_comb begin
        vol_d    = vol_q;
        timer_d  = timer_q;
        frozen_d = frozen_q;
        if (trigger) begin
            vol_d    = cfg.init_vol;
            timer_d  = cfg.period;
            frozen_d = 1'b0;
        end else if (env_clk && (cfg.period != 3'd0) && !frozen_q) begin
            if (expire) begin
                timer_d = cfg.period;
                if (at_limit) begin
                    frozen_d = 1'b1;
                end else if (cfg.dir == ENV_UP) begin
                    vol_d = vol_q + 4'd1;
                end else begin
                    vol_d = vol_q - 4'd1;
                end
            end else begin
                timer_d = timer_q - 3'd1;
            end
        end
    end

    // Envelope state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vol_q    <= 4'd0;
            timer_q  <= 3'd0;
            frozen_q <= 1'b0;
        end else begin
            vol_q    <= vol_d;
            timer_q  <= timer_d;
            frozen_q <= frozen_d;
        end
    end

endmodule

// File: rtl/ch2_sequencer.sv
// APU channel 2 (pulse) controller.
// Frame sequencer, length counter, envelope and duty timer.
module ch2_sequencer
    import apu_pkg::*;
(
    input  logic        clk,
    input  logic        napu_reset,
    input  logic        frame_tick,
    input  logic        freq_tick,
    input  logic [1:0]  nr21_duty,
    input  logic [5:0]  nr21_len,
    input  logic        nr21_len_wr,
    input  logic [7:0]  nr22,
    input  logic [10:0] freq,
    input  logic        len_en,
    input  logic        trigger,
    output logic        ch2_on,
    output logic [3:0]  ch2_out,
    output logic [3:0]  ch2_vol,
    output logic [2:0]  duty_step
);

    logic [2:0]  fs_step_q;
    logic [2:0]  fs_step_d;
    logic [6:0]  len_cnt_q;
    logic [6:0]  len_cnt_d;
    logic [6:0]  len_base;
    logic        len_expire;
    logic        ch2_on_q;
    logic        ch2_on_d;
    logic [10:0] ftimer_q;
    logic [10:0] ftimer_d;
    logic [2:0]  duty_step_q;
    logic [2:0]  duty_step_d;
    logic [3:0]  ch2_out_q;
    logic [3:0]  ch2_out_d;
    logic [3:0]  vol_q;
    logic [3:0]  vol_d;
    logic        len_clk;
    logic        env_clk;
    logic        dac_on;
    env_cfg_t    env_cfg;

    assign len_clk = frame_tick && FS_LEN_MASK[fs_step_q];
    assign env_clk = frame_tick && (fs_step_q == FS_ENV_STEP);
    assign dac_on  = (nr22[7:3] != 5'd0);
    assign env_cfg = env_cfg_t'(nr22);

    // Frame sequencer step advances on every frame tick.
    always_comb begin
        fs_step_d = fs_step_q;
        if (frame_tick) begin
            fs_step_d = fs_step_q + 3'd1;
        end
    end

    // Length: a register load lands before the trigger's zero check.
    always_comb begin
        len_expire = 1'b0;
        len_base   = nr21_len_wr ? (LEN_MAX - {1'b0, nr21_len})
                                 : len_cnt_q;
        len_cnt_d  = len_base;
        if (trigger) begin
            if (len_base == 7'd0) begin
                len_cnt_d = LEN_MAX;
            end
        end else if (!nr21_len_wr && len_clk && len_en
                     && (len_cnt_q != 7'd0)) begin
            len_cnt_d  = len_cnt_q - 7'd1;
            len_expire = (len_cnt_q == 7'd1);
        end
    end

    // Channel enable: DAC off beats trigger, trigger beats expiry.
    always_comb begin
        ch2_on_d = ch2_on_q;
        if (!dac_on) begin
            ch2_on_d = 1'b0;
        end else if (trigger) begin
            ch2_on_d = 1'b1;
        end else if (len_expire) begin
            ch2_on_d = 1'b0;
        end
    end

    // Frequency timer counts up to 2047, then reloads and steps duty.
    always_comb begin
        ftimer_d    = ftimer_q;
        duty_step_d = duty_step_q;
        if (trigger) begin
            ftimer_d = freq;
        end else if (freq_tick) begin
            if (ftimer_q == 11'h7FF) begin
                ftimer_d    = freq;
                duty_step_d = duty_step_q + 3'd1;
            end else begin
                ftimer_d = ftimer_q + 11'd1;
            end
        end
    end

    // Sample from next-state values so it lines up with step and volume.
    always_comb begin
        ch2_out_d = 4'd0;
        if (ch2_on_d && duty_bit(nr21_duty, duty_step_d)) begin
            ch2_out_d = vol_d;
        end
    end

    apu_envelope u_env (
        .clk     (clk),
        .rst_n   (napu_reset),
        .trigger (trigger),
        .env_clk (env_clk),
        .cfg     (env_cfg),
        .vol_q   (vol_q),
        .vol_d   (vol_d)
    );

    // Sequencer, length, timer and output registers.
    always_ff @(posedge clk or negedge napu_reset) begin
        if (!napu_reset) begin
            fs_step_q   <= 3'd0;
            len_cnt_q   <= 7'd0;
            ch2_on_q    <= 1'b0;
            ftimer_q    <= 11'd0;
            duty_step_q <= 3'd0;
            ch2_out_q   <= 4'd0;
        end else begin
            fs_step_q   <= fs_step_d;
            len_cnt_q   <= len_cnt_d;
            ch2_on_q    <= ch2_on_d;
            ftimer_q    <= ftimer_d;
            duty_step_q <= duty_step_d;
            ch2_out_q   <= ch2_out_d;
        end
    end

    assign ch2_on    = ch2_on_q;
    assign ch2_out   = ch2_out_q;
    assign ch2_vol   = vol_q;
    assign duty_step = duty_step_q;

endmodule

// File: tb/tb_ch2_sequencer.sv
// Testbench for ch2_sequencer.
// Scenario table, corner sequences, then random run against a model.
module tb_ch2_sequencer;

    logic        clk = 1'b0;
    logic        napu_reset = 1'b0;
    logic        frame_tick = 1'b0;
    logic        freq_tick = 1'b0;
    logic [1:0]  nr21_duty = 2'd0;
    logic [5:0]  nr21_len = 6'd0;
    logic        nr21_len_wr = 1'b0;
    logic [7:0]  nr22 = 8'd0;
    logic [10:0] freq = 11'd0;
    logic        len_en = 1'b0;
    logic        trigger = 1'b0;
    logic        ch2_on;
    logic [3:0]  ch2_out;
    logic [3:0]  ch2_vol;
    logic [2:0]  duty_step;

    ch2_sequencer dut (
        .clk         (clk),
        .napu_reset  (napu_reset),
        .frame_tick  (frame_tick),
        .freq_tick   (freq_tick),
        .nr21_duty   (nr21_duty),
        .nr21_len    (nr21_len),
        .nr21_len_wr (nr21_len_wr),
        .nr22        (nr22),
        .freq        (freq),
        .len_en      (len_en),
        .trigger     (trigger),
        .ch2_on      (ch2_on),
        .ch2_out     (ch2_out),
        .ch2_vol     (ch2_vol),
        .duty_step   (duty_step)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    bit chk = 0;

    // Duty patterns written as in the datasheet, leftmost char = step 0.
    string duty_str[4];

    // Reference model state (plain integers).
    int m_fs, m_len, m_vol, m_envt, m_left, m_step, m_out;
    bit m_on, m_frozen;

    function automatic bit duty_hi(int sel, int step);
        return duty_str[sel].getc(step) == 8'h31;
    endfunction

    function automatic void model_reset();
        m_fs = 0; m_len = 0; m_vol = 0; m_envt = 0;
        m_left = 2048; m_step = 0; m_out = 0;
        m_on = 0; m_frozen = 0;
    endfunction

    function automatic void model_edge();
        int per;
        bit up;
        bit dac;
        bit lclk;
        bit eclk;
        int len;
        bit expired;
        per  = int'(nr22[2:0]);
        up   = nr22[3];
        dac  = (nr22[7:3] != 0);
        lclk = frame_tick && (m_fs % 2 == 0);
        eclk = frame_tick && (m_fs == 7);
        expired = 0;
        len = nr21_len_wr ? 64 - int'(nr21_len) : m_len;
        if (trigger) begin
            if (len == 0) len = 64;
        end else if (!nr21_len_wr && lclk && len_en && len > 0) begin
            len--;
            expired = (len == 0);
        end
        m_len = len;
        if (trigger) begin
            m_vol = int'(nr22[7:4]);
            m_envt = per;
            m_frozen = 0;
        end else if (eclk && per != 0 && !m_frozen) begin
            if (m_envt <= 1) begin
                m_envt = per;
                if ((up && m_vol == 15) || (!up && m_vol == 0))
                    m_frozen = 1;
                else
                    m_vol = up ? m_vol + 1 : m_vol - 1;
            end else begin
                m_envt--;
            end
        end
        if (!dac) m_on = 0;
        else if (trigger) m_on = 1;
        else if (expired) m_on = 0;
        if (trigger) begin
            m_left = 2048 - int'(freq);
        end else if (freq_tick) begin
            m_left--;
            if (m_left == 0) begin
                m_step = (m_step + 1) % 8;
                m_left = 2048 - int'(freq);
            end
        end
        if (frame_tick) m_fs = (m_fs + 1) % 8;
        m_out = (m_on && duty_hi(int'(nr21_duty), m_step)) ? m_vol : 0;
    endfunction

    task automatic check(string nm, int act, int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        if (!napu_reset) model_reset();
        else model_edge();
        @(posedge clk);
        #1;
        if (chk) begin
            n_vec++;
            if (ch2_on !== m_on || ch2_vol !== 4'(m_vol)
                || ch2_out !== 4'(m_out) || duty_step !== 3'(m_step)) begin
                n_bad++;
                $display("FAIL rand @%0t: on/vol/out/step got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                         $time, ch2_on, ch2_vol, ch2_out, duty_step,
                         m_on, m_vol, m_out, m_step);
            end
        end
    endtask

    task automatic clr_strobes();
        frame_tick = 0; freq_tick = 0; trigger = 0; nr21_len_wr = 0;
    endtask

    task automatic do_reset();
        clr_strobes();
        napu_reset = 0;
        tick();
        tick();
        napu_reset = 1;
        tick();
    endtask

    task automatic frame_ticks(int n);
        repeat (n) begin
            frame_tick = 1;
            tick();
            frame_tick = 0;
            tick();
        end
    endtask

    typedef struct {
        string      name;
        logic [7:0] r22;
        logic [5:0] len;
        logic       len_en;
        int         ticks;
        logic       exp_on;
        logic [3:0] exp_vol;
        logic [3:0] exp_out;
    } vec_t;

    vec_t vt[$];

    task automatic add(string nm, logic [7:0] r22, logic [5:0] len,
                       logic le, int tk, logic on, logic [3:0] vol,
                       logic [3:0] outv);
        vec_t v;
        v = '{nm, r22, len, le, tk, on, vol, outv};
        vt.push_back(v);
    endtask

    initial begin
        duty_str[0] = "00000001";
        duty_str[1] = "10000001";
        duty_str[2] = "10000111";
        duty_str[3] = "01111110";
        model_reset();

        // Reset state
        do_reset();
        check("rst_on", ch2_on, 0);
        check("rst_out", ch2_out, 0);
        check("rst_vol", ch2_vol, 0);
        check("rst_step", duty_step, 0);

        // Scenario table: length write + trigger together, then n frame ticks.
        add("len62_t0", 8'hF0, 6'd62, 1, 0, 1, 15, 15);
        add("len62_t1", 8'hF0, 6'd62, 1, 1, 1, 15, 15);
        add("len62_t2", 8'hF0, 6'd62, 1, 2, 1, 15, 15);
        add("len62_t3", 8'hF0, 6'd62, 1, 3, 0, 15, 0);
        add("len63_noen", 8'hF0, 6'd63, 0, 16, 1, 15, 15);
        add("len63_en", 8'hF0, 6'd63, 1, 1, 0, 15, 0);
        add("envdn_7", 8'h31, 6'd0, 0, 7, 1, 3, 3);
        add("envdn_8", 8'h31, 6'd0, 0, 8, 1, 2, 2);
        add("envdn_16", 8'h31, 6'd0, 0, 16, 1, 1, 1);
        add("envdn_24", 8'h31, 6'd0, 0, 24, 1, 0, 0);
        add("envdn_40", 8'h31, 6'd0, 0, 40, 1, 0, 0);
        add("envdn_p2_8", 8'h32, 6'd0, 0, 8, 1, 3, 3);
        add("envdn_p2_16", 8'h32, 6'd0, 0, 16, 1, 2, 2);
        add("envup_0", 8'hE9, 6'd0, 0, 0, 1, 14, 14);
        add("envup_8", 8'hE9, 6'd0, 0, 8, 1, 15, 15);
        add("envup_24", 8'hE9, 6'd0, 0, 24, 1, 15, 15);
        add("dacoff", 8'h07, 6'd0, 0, 0, 0, 0, 0);

        foreach (vt[i]) begin
            do_reset();
            nr22 = vt[i].r22;
            nr21_len = vt[i].len;
            len_en = vt[i].len_en;
            nr21_duty = 2'd1;
            freq = 11'd0;
            nr21_len_wr = 1;
            trigger = 1;
            tick();
            clr_strobes();
            frame_ticks(vt[i].ticks);
            check({vt[i].name, "_on"}, ch2_on, vt[i].exp_on);
            check({vt[i].name, "_vol"}, ch2_vol, vt[i].exp_vol);
            check({vt[i].name, "_out"}, ch2_out, vt[i].exp_out);
        end

        // DAC switched off without trigger drops the channel
        do_reset();
        nr22 = 8'hF0; trigger = 1;
        tick();
        clr_strobes();
        check("dac_pre_on", ch2_on, 1);
        nr22 = 8'h07;
        tick();
        check("dac_off_on", ch2_on, 0);

        // Trigger on a length clock with len_cnt = 0 -> 64 clocks to expire
        do_reset();
        nr22 = 8'hF0; len_en = 1; trigger = 1; frame_tick = 1;
        tick();
        clr_strobes();
        for (int i = 1; i <= 128; i++) begin
            frame_tick = 1;
            tick();
            frame_tick = 0;
            tick();
            if (i == 126) check("coll_126_on", ch2_on, 1);
            if (i == 128) check("coll_128_on", ch2_on, 0);
        end
        len_en = 0;

        // Duty/frequency: freq 2044 -> one step per 4 ticks
        do_reset();
        nr22 = 8'hA0; nr21_duty = 2'd2; freq = 11'd2044; trigger = 1;
        tick();
        clr_strobes();
        check("duty_n0_step", duty_step, 0);
        check("duty_n0_out", ch2_out, 10);
        freq_tick = 1;
        for (int n = 1; n <= 43; n++) begin
            int es;
            tick();
            es = (n / 4) % 8;
            check($sformatf("duty_n%0d_step", n), duty_step, es);
            check($sformatf("duty_n%0d_out", n), ch2_out,
                  duty_hi(2, es) ? 10 : 0);
        end
        // Timer sits at 2047; trigger with freq_tick reloads without a step
        trigger = 1;
        tick();
        trigger = 0;
        check("trig_ftick_step", duty_step, 2);
        repeat (3) tick();
        check("reload_3_step", duty_step, 2);
        tick();
        check("reload_4_step", duty_step, 3);
        clr_strobes();

        // Asynchronous reset mid-operation
        frame_ticks(3);
        check("arst_pre_on", ch2_on, 1);
        #2;
        napu_reset = 0;
        #1;
        check("arst_on", ch2_on, 0);
        check("arst_vol", ch2_vol, 0);
        check("arst_out", ch2_out, 0);
        check("arst_step", duty_step, 0);
        model_reset();
        tick();
        napu_reset = 1;
        tick();
        check("arst_fs_step", dut.fs_step_q, 0);

        // Random run against the reference model
        do_reset();
        nr22 = 8'hF0; len_en = 1; freq = 11'd2045;
        chk = 1;
        for (int c = 0; c < 4000; c++) begin
            frame_tick = ($urandom % 4) == 0;
            freq_tick = ($urandom % 2) == 0;
            trigger = ($urandom % 40) == 0;
            nr21_len_wr = ($urandom % 25) == 0;
            nr21_len = 6'($urandom_range(48, 63));
            if ($urandom % 100 == 0) len_en = ~len_en;
            if ($urandom % 100 == 0) nr21_duty = 2'($urandom);
            if ($urandom % 200 == 0) freq = 11'($urandom_range(2038, 2047));
            if ($urandom % 120 == 0) begin
                case ($urandom % 8)
                    0: nr22 = 8'hF0;
                    1: nr22 = 8'h31;
                    2: nr22 = 8'hE9;
                    3: nr22 = 8'h07;
                    4: nr22 = 8'h8B;
                    5: nr22 = 8'h12;
                    6: nr22 = 8'h00;
                    default: nr22 = 8'($urandom);
                endcase
            end
            tick();
        end
        chk = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
